// File: rtl/vdp_pkg.sv
// Shared VDP map definitions.
// Holds the map geometry widths, the bit of the stride register that selects a
// 128-column (two 64-column page) map, and the state encoding of the map region writer.
package vdp_pkg;

    localparam int MAP_ADDR_W     = 15;  // VRAM 16-bit word address width
    localparam int MAP_ROW_W      = 6;   // tile rows per map page (64)
    localparam int MAP_COL_W      = 7;   // columns across both pages (128)
    localparam int STRIDE_128_BIT = 7;   // stride bit that enables the second 64-column page

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } map_wr_state_e;

endpackage

// File: rtl/vdp_map_cell_address.sv
// Map cell to VRAM word address.
// This is the single definition of where a map entry lives. The map fetch path and
// the region writer both use it, so CPU edits land exactly where the renderer reads.
// Ports:
//   map_base_address  in  map base word address
//   map_128_col       in  1 = 128-column map, column[6] selects page 1
//   row               in  tile row 0..63
//   column            in  column 0..127 (bit 6 ignored on 64-column maps)
//   address           out ({page, row, column[5:0]} + base) mod 2^ADDR_W
module vdp_map_cell_address
    import vdp_pkg::*;
#(
    parameter int ADDR_W = MAP_ADDR_W
) (
    input  logic [ADDR_W-1:0]    map_base_address,
    input  logic                 map_128_col,
    input  logic [MAP_ROW_W-1:0] row,
    input  logic [MAP_COL_W-1:0] column,
    output logic [ADDR_W-1:0]    address
);

    logic                              page;
    logic [MAP_ROW_W+MAP_COL_W-1:0]    cell_offset;

    // On a 64-column map, column[6] is dropped so that columns wrap within the page.
    assign page        = map_128_col & column[MAP_COL_W-1];
    assign cell_offset = {page, row, column[MAP_COL_W-2:0]};
    assign address     = map_base_address + ADDR_W'(cell_offset);

endmodule

// File: rtl/vdp_map_region_writer.sv
// Map region writer: writes a rectangle of map entries to VRAM, either a constant
// (fill mode) or entries taken from a valid/ready stream, row-major order.
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   start, abort                       job request (params sampled when idle) / cancel
//   map_base_address, stride           map placement; stride[7] = 128-column map
//   col_start, row_start               top-left cell of the region
//   width_m1, height_m1                region size minus one
//   fill_mode, fill_data               1 = write fill_data, 0 = consume src stream
//   src_data, src_valid, src_ready     entry stream
//   vram_address, vram_data, vram_we   write request, held until vram_ready
//   vram_ready                         arbiter accepts on edge with vram_we & vram_ready
//   busy, done                         job running / 1-cycle completion pulse
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; fill mode preloads the first entry on start
// RUN   | fetching entries into the output register and writing them out
// DONE  | last write accepted; done pulse for one cycle
module vdp_map_region_writer
    import vdp_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = MAP_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] map_base_address,
    input  logic [7:0]            stride,
    input  logic [MAP_COL_W-1:0]  col_start,
    input  logic [MAP_ROW_W-1:0]  row_start,
    input  logic [MAP_COL_W-1:0]  width_m1,
    input  logic [MAP_ROW_W-1:0]  height_m1,
    input  logic                  fill_mode,
    input  logic [DATA_WIDTH-1:0] fill_data,
    input  logic [DATA_WIDTH-1:0] src_data,
    input  logic                  src_valid,
    output logic                  src_ready,
    output logic [ADDR_WIDTH-1:0] vram_address,
    output logic [DATA_WIDTH-1:0] vram_data,
    output logic                  vram_we,
    input  logic                  vram_ready,
    output logic                  busy,
    output logic                  done
);

    map_wr_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  map_128_q, map_128_d;
    logic [MAP_COL_W-1:0]  col_start_q, col_start_d;
    logic [MAP_ROW_W-1:0]  row_start_q, row_start_d;
    logic [MAP_COL_W-1:0]  width_m1_q, width_m1_d;
    logic [MAP_ROW_W-1:0]  height_m1_q, height_m1_d;
    logic                  fill_mode_q, fill_mode_d;
    logic [DATA_WIDTH-1:0] fill_data_q, fill_data_d;

    // x/y count accepted writes; fx/fy track the next entry to load.
    logic [MAP_COL_W-1:0]  x_q, x_d, fx_q, fx_d;
    logic [MAP_ROW_W-1:0]  y_q, y_d, fy_q, fy_d;
    logic                  fetch_done_q, fetch_done_d;

    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic                  idle;
    logic [ADDR_WIDTH-1:0] eff_base;
    logic                  eff_map_128;
    logic [MAP_COL_W-1:0]  eff_col_start, eff_width_m1;
    logic [MAP_ROW_W-1:0]  eff_row_start, eff_height_m1;
    logic                  eff_fill_mode;
    logic [DATA_WIDTH-1:0] eff_fill_data;
    logic [MAP_COL_W-1:0]  fetch_col;
    logic [MAP_ROW_W-1:0]  fetch_row;
    logic [ADDR_WIDTH-1:0] fetch_address;
    logic                  start_accept, out_free, accept, last_accept;
    logic                  src_ready_int, load;
    logic                  unused_stride_bits;

    assign unused_stride_bits = ^stride[STRIDE_128_BIT-1:0];

    // In IDLE the live inputs drive the fetch path so fill mode can load its first
    // entry on the start cycle; afterwards only the latched copies are used.
    assign idle          = (state_q == IDLE);
    assign eff_base      = idle ? map_base_address        : base_q;
    assign eff_map_128   = idle ? stride[STRIDE_128_BIT]  : map_128_q;
    assign eff_col_start = idle ? col_start               : col_start_q;
    assign eff_row_start = idle ? row_start               : row_start_q;
    assign eff_width_m1  = idle ? width_m1                : width_m1_q;
    assign eff_height_m1 = idle ? height_m1               : height_m1_q;
    assign eff_fill_mode = idle ? fill_mode               : fill_mode_q;
    assign eff_fill_data = idle ? fill_data               : fill_data_q;

    assign fetch_col = eff_col_start + fx_q;
    assign fetch_row = eff_row_start + fy_q;

    vdp_map_cell_address #(
        .ADDR_W(ADDR_WIDTH)
    ) u_cell_address (
        .map_base_address(eff_base),
        .map_128_col     (eff_map_128),
        .row             (fetch_row),
        .column          (fetch_col),
        .address         (fetch_address)
    );

    assign start_accept  = idle & start & ~abort;
    assign out_free      = ~we_q | vram_ready;
    assign accept        = we_q & vram_ready;
    assign last_accept   = (state_q == RUN) & accept &
                           (x_q == width_m1_q) & (y_q == height_m1_q);
    assign src_ready_int = (state_q == RUN) & ~fill_mode_q & ~fetch_done_q & out_free;
    assign load          = ~abort &
                           ((start_accept & fill_mode) |
                            ((state_q == RUN) & fill_mode_q & ~fetch_done_q & out_free) |
                            (src_ready_int & src_valid));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            base_q       <= '0;
            map_128_q    <= 1'b0;
            col_start_q  <= '0;
            row_start_q  <= '0;
            width_m1_q   <= '0;
            height_m1_q  <= '0;
            fill_mode_q  <= 1'b0;
            fill_data_q  <= '0;
            x_q          <= '0;
            y_q          <= '0;
            fx_q         <= '0;
            fy_q         <= '0;
            fetch_done_q <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            map_128_q    <= map_128_d;
            col_start_q  <= col_start_d;
            row_start_q  <= row_start_d;
            width_m1_q   <= width_m1_d;
            height_m1_q  <= height_m1_d;
            fill_mode_q  <= fill_mode_d;
            fill_data_q  <= fill_data_d;
            x_q          <= x_d;
            y_q          <= y_d;
            fx_q         <= fx_d;
            fy_q         <= fy_d;
            fetch_done_q <= fetch_done_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start)       state_d = RUN;
                RUN:     if (last_accept) state_d = DONE;
                DONE:                     state_d = IDLE;
                default:                  state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign src_ready    = src_ready_int;
    assign vram_we      = we_q;
    assign vram_address = addr_q;
    assign vram_data    = data_q;

    always_comb begin
        base_d       = base_q;
        map_128_d    = map_128_q;
        col_start_d  = col_start_q;
        row_start_d  = row_start_q;
        width_m1_d   = width_m1_q;
        height_m1_d  = height_m1_q;
        fill_mode_d  = fill_mode_q;
        fill_data_d  = fill_data_q;
        x_d          = x_q;
        y_d          = y_q;
        fx_d         = fx_q;
        fy_d         = fy_q;
        fetch_done_d = fetch_done_q;
        we_d         = we_q;
        addr_d       = addr_q;
        data_d       = data_q;

        if (start_accept) begin
            base_d      = map_base_address;
            map_128_d   = stride[STRIDE_128_BIT];
            col_start_d = col_start;
            row_start_d = row_start;
            width_m1_d  = width_m1;
            height_m1_d = height_m1;
            fill_mode_d = fill_mode;
            fill_data_d = fill_data;
        end

        // Counters restart from zero for every job, including after an abort.
        if ((state_q != RUN) || abort) begin
            x_d          = '0;
            y_d          = '0;
            fx_d         = '0;
            fy_d         = '0;
            fetch_done_d = 1'b0;
        end else if (accept) begin
            if (x_q == width_m1_q) begin
                x_d = '0;
                y_d = y_q + MAP_ROW_W'(1);
            end else begin
                x_d = x_q + MAP_COL_W'(1);
            end
        end

        // fx/fy are zero in IDLE, so the start-cycle preload advances from entry 0.
        if (load) begin
            addr_d = fetch_address;
            data_d = eff_fill_mode ? eff_fill_data : src_data;
            if (fx_q == eff_width_m1) begin
                fx_d = '0;
                if (fy_q == eff_height_m1) begin
                    fetch_done_d = 1'b1;
                end else begin
                    fy_d = fy_q + MAP_ROW_W'(1);
                end
            end else begin
                fx_d = fx_q + MAP_COL_W'(1);
            end
        end

        if (abort) begin
            we_d = 1'b0;
        end else if (load) begin
            we_d = 1'b1;
        end else if (accept) begin
            we_d = 1'b0;
        end
    end

endmodule
